// File: rtl/pucch1_pkg.sv
// ============================================================================
// Module      : pucch1_pkg
// Description : Shared PUCCH format 1 definitions: spreading-factor limits,
//               nSF==4 orthogonal cover phase table and the {nSF,phi}
//               twiddle ROM used by the despreader and the transmit spreader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pucch1_pkg;

    localparam logic [2:0] NSF_MIN = 3'd2;
    localparam logic [2:0] NSF_MAX = 3'd7;

    // Twiddle ROM word width: Q1.15, magnitude scaled by 2^15-1
    localparam int TW_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] nsf;
        logic [2:0] occi;
    } cfg_t;

    // Raw two's-complement words; consumers apply $signed
    typedef struct packed {
        logic [TW_W-1:0] c;
        logic [TW_W-1:0] s;
    } twiddle_t;

    // nSF==4 cover: each row marks the beats whose phase is 2 (i.e. -1)
    function automatic logic [2:0] occ4_phi(input logic [1:0] occi, input logic [1:0] m);
        logic [3:0] row;
        case (occi)
            2'd0:    row = 4'b0000;
            2'd1:    row = 4'b1010;
            2'd2:    row = 4'b1100;
            default: row = 4'b0110;
        endcase
        return row[m] ? 3'd2 : 3'd0;
    endfunction

    function automatic twiddle_t mk_tw(input int c, input int s);
        twiddle_t t;
        t.c = c[TW_W-1:0];
        t.s = s[TW_W-1:0];
        return t;
    endfunction

    // cos/sin(2*pi*phi/nSF) * (2^15-1), rounded half away from zero.
    // Indexed as {nSF,phi}; written in octal so the digits read nSF then phi.
    function automatic twiddle_t tw_lookup(input logic [2:0] nsf, input logic [2:0] phi);
        twiddle_t t;
        case ({nsf, phi})
            6'o20: t = mk_tw( 32767,      0);
            6'o21: t = mk_tw(-32767,      0);
            6'o30: t = mk_tw( 32767,      0);
            6'o31: t = mk_tw(-16384,  28377);
            6'o32: t = mk_tw(-16384, -28377);
            6'o40: t = mk_tw( 32767,      0);
            6'o41: t = mk_tw(     0,  32767);
            6'o42: t = mk_tw(-32767,      0);
            6'o43: t = mk_tw(     0, -32767);
            6'o50: t = mk_tw( 32767,      0);
            6'o51: t = mk_tw( 10126,  31163);
            6'o52: t = mk_tw(-26509,  19260);
            6'o53: t = mk_tw(-26509, -19260);
            6'o54: t = mk_tw( 10126, -31163);
            6'o60: t = mk_tw( 32767,      0);
            6'o61: t = mk_tw( 16384,  28377);
            6'o62: t = mk_tw(-16384,  28377);
            6'o63: t = mk_tw(-32767,      0);
            6'o64: t = mk_tw(-16384, -28377);
            6'o65: t = mk_tw( 16384, -28377);
            6'o70: t = mk_tw( 32767,      0);
            6'o71: t = mk_tw( 20430,  25618);
            6'o72: t = mk_tw( -7291,  31945);
            6'o73: t = mk_tw(-29522,  14217);
            6'o74: t = mk_tw(-29522, -14217);
            6'o75: t = mk_tw( -7291, -31945);
            6'o76: t = mk_tw( 20430, -25618);
            default: t = mk_tw(0, 0);
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pucch1_despread_if.sv
// ============================================================================
// Module      : pucch1_despread_if
// Description : Control, sample and result bus of the PUCCH1 despreader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pucch1_despread_if #(
    parameter int DW = 16,
    parameter int AW = 20
);
    logic                 i_start;
    logic [2:0]           i_nsf;
    logic [2:0]           i_occi;
    logic                 i_valid;
    logic signed [DW-1:0] i_re;
    logic signed [DW-1:0] i_im;
    logic                 o_ready;
    logic                 o_busy;
    logic                 o_err;
    logic                 o_valid;
    logic signed [AW-1:0] o_re;
    logic signed [AW-1:0] o_im;

    modport master (
        output i_start, i_nsf, i_occi, i_valid, i_re, i_im,
        input  o_ready, o_busy, o_err, o_valid, o_re, o_im
    );

    modport slave (
        input  i_start, i_nsf, i_occi, i_valid, i_re, i_im,
        output o_ready, o_busy, o_err, o_valid, o_re, o_im
    );
endinterface

`default_nettype wire

// File: rtl/pucch1_occ_gen.sv
// ============================================================================
// Module      : pucch1_occ_gen
// Description : Per-beat orthogonal cover phase generator. Produces phi(m)
//               for the current beat and flags the last beat of the hop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pucch1_occ_gen
    import pucch1_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_clr,
    input  wire logic       i_adv,
    input  wire logic [2:0] i_nsf,
    input  wire logic [2:0] i_occi,
    output logic [2:0]      o_phi,
    output logic            o_last
);

    logic [2:0] r_m;
    logic [2:0] r_phi;
    logic [3:0] w_sum;
    logic [2:0] w_phi_nxt;

    // phi(m+1) = phi(m)+occi folded back by one conditional subtract
    always_comb begin
        w_sum     = {1'b0, r_phi} + {1'b0, i_occi};
        w_phi_nxt = w_sum[2:0];
        if (w_sum >= {1'b0, i_nsf}) begin
            w_phi_nxt = 3'(w_sum - {1'b0, i_nsf});
        end
    end

    // Beat index and recurrence phase, restarted at every hop start
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_m   <= 3'd0;
            r_phi <= 3'd0;
        end else if (i_adv) begin
            r_m   <= r_m + 3'd1;
            r_phi <= w_phi_nxt;
        end
    end

    // nSF==4 covers are not a linear recurrence, so they come from the table
    assign o_phi  = (i_nsf == 3'd4) ? occ4_phi(i_occi[1:0], r_m[1:0]) : r_phi;
    assign o_last = (r_m == (i_nsf - 3'd1));

endmodule

`default_nettype wire

// File: rtl/pucch1_despread.sv
// ============================================================================
// Module      : pucch1_despread
// Description : PUCCH format 1 block-wise despreader. Derotates one
//               correlated sample per symbol by conj(w_i(m)) and sums the
//               hop into a single complex value for the UCI detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pucch1_despread
    import pucch1_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = TW_W,   // coefficient ROM is built for CW == TW_W
    parameter int AW = 20
) (
    input  wire logic            clk,
    input  wire logic            rst,
    pucch1_despread_if.slave     ifc
);

    localparam int c_PW = DW + CW + 1;
    localparam logic signed [c_PW-1:0] c_RND =
        {{(c_PW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};

    state_t r_state;
    state_t w_state_nxt;
    cfg_t   r_cfg;

    logic w_cfg_ok;
    logic w_load;
    logic w_err;
    logic w_fire;
    logic w_accept;
    logic w_last;
    logic [2:0] w_phi;

    logic                 r_s1_vld;
    logic signed [DW:0]   r_s1_re;
    logic signed [DW:0]   r_s1_im;
    logic signed [AW-1:0] r_acc_re;
    logic signed [AW-1:0] r_acc_im;

    logic                 r_o_valid;
    logic                 r_o_err;
    logic signed [AW-1:0] r_o_re;
    logic signed [AW-1:0] r_o_im;

    twiddle_t               w_tw;
    logic signed [CW-1:0]   w_c;
    logic signed [CW-1:0]   w_s;
    logic signed [c_PW-1:0] w_re_x;
    logic signed [c_PW-1:0] w_im_x;
    logic signed [c_PW-1:0] w_c_x;
    logic signed [c_PW-1:0] w_s_x;
    logic signed [c_PW-1:0] w_p_re;
    logic signed [c_PW-1:0] w_p_im;
    logic signed [DW:0]     w_d_re;
    logic signed [DW:0]     w_d_im;

    assign w_cfg_ok = (ifc.i_nsf >= NSF_MIN) && (ifc.i_nsf <= NSF_MAX) &&
                      (ifc.i_occi < ifc.i_nsf);

    // A beat arriving together with i_start belongs to no hop and is dropped
    assign w_accept = ifc.i_valid && (r_state == ST_ACC) && !ifc.i_start;

    pucch1_occ_gen u_occ_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (ifc.i_start),
        .i_adv  (w_accept),
        .i_nsf  (r_cfg.nsf),
        .i_occi (r_cfg.occi),
        .o_phi  (w_phi),
        .o_last (w_last)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; i_start from any state restarts or aborts the hop
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_fire      = 1'b0;
        if (ifc.i_start) begin
            if (w_cfg_ok) begin
                w_state_nxt = ST_ACC;
                w_load      = 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
                w_err       = 1'b1;
            end
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept && w_last) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Stage 1 empty means the last beat is already in the sum
                    if (!r_s1_vld) begin
                        w_fire      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Hop configuration captured only on a valid start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg <= '0;
        end else if (w_load) begin
            r_cfg <= '{nsf: ifc.i_nsf, occi: ifc.i_occi};
        end
    end

    // Stage 1 arithmetic: complex multiply by conj(w), rounded back to DW+1
    always_comb begin
        w_tw   = tw_lookup(r_cfg.nsf, w_phi);
        w_c    = $signed(w_tw.c);
        w_s    = $signed(w_tw.s);
        w_re_x = $signed({{(c_PW-DW){ifc.i_re[DW-1]}}, ifc.i_re});
        w_im_x = $signed({{(c_PW-DW){ifc.i_im[DW-1]}}, ifc.i_im});
        w_c_x  = $signed({{(c_PW-CW){w_c[CW-1]}}, w_c});
        w_s_x  = $signed({{(c_PW-CW){w_s[CW-1]}}, w_s});
        w_p_re = w_re_x * w_c_x + w_im_x * w_s_x;
        w_p_im = w_im_x * w_c_x - w_re_x * w_s_x;
        // phi==0 is the identity; skipping the multiplier keeps it exact
        if (w_phi == 3'd0) begin
            w_d_re = {ifc.i_re[DW-1], ifc.i_re};
            w_d_im = {ifc.i_im[DW-1], ifc.i_im};
        end else begin
            w_d_re = (DW+1)'((w_p_re + c_RND) >>> (CW-1));
            w_d_im = (DW+1)'((w_p_im + c_RND) >>> (CW-1));
        end
    end

    // Stage 1 register; i_start flushes any beat in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_re  <= '0;
            r_s1_im  <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_re <= w_d_re;
                r_s1_im <= w_d_im;
            end
        end
    end

    // Stage 2: wrapping accumulator, cleared at every hop start
    always_ff @(posedge clk) begin
        if (rst || ifc.i_start) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (r_s1_vld) begin
            r_acc_re <= r_acc_re + $signed({{(AW-DW-1){r_s1_re[DW]}}, r_s1_re});
            r_acc_im <= r_acc_im + $signed({{(AW-DW-1){r_s1_im[DW]}}, r_s1_im});
        end
    end

    // Result and status registers; the result holds until the next hop ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid <= 1'b0;
            r_o_err   <= 1'b0;
            r_o_re    <= '0;
            r_o_im    <= '0;
        end else begin
            r_o_valid <= w_fire;
            r_o_err   <= w_err;
            if (w_fire) begin
                r_o_re <= r_acc_re;
                r_o_im <= r_acc_im;
            end
        end
    end

    assign ifc.o_ready = (r_state == ST_ACC);
    assign ifc.o_busy  = (r_state != ST_IDLE);
    assign ifc.o_err   = r_o_err;
    assign ifc.o_valid = r_o_valid;
    assign ifc.o_re    = r_o_re;
    assign ifc.o_im    = r_o_im;

endmodule

`default_nettype wire

// File: tb/tb_pucch1_despread.sv
// ============================================================================
// Module      : tb_pucch1_despread
// Description : Self-checking bench for pucch1_despread with a floating-point
//               derived reference model of the despreading rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pucch1_despread;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int AW = 20;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pucch1_despread_if #(.DW(DW), .AW(AW)) ifc();

    pucch1_despread #(.DW(DW), .CW(CW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int n_ovld  = 0;
    int bre[8];
    int bim[8];

    // Every o_valid pulse, counted once per cycle
    always @(negedge clk) begin
        if (ifc.o_valid === 1'b1) n_ovld++;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_s16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    // Reference: phase from the closed form (m*occi) mod nSF or the nSF=4 cover
    function automatic int ref_phi(input int nsf, input int occi, input int m);
        int t4[4][4];
        t4 = '{'{0,0,0,0}, '{0,2,0,2}, '{0,0,2,2}, '{0,2,2,0}};
        if (nsf == 4) return t4[occi][m];
        return (m * occi) % nsf;
    endfunction

    function automatic longint rnd(input real x);
        real    a;
        longint v;
        a = (x < 0.0) ? -x : x;
        v = longint'($floor(a + 0.5 + 1.0e-6));
        return (x < 0.0) ? -v : v;
    endfunction

    function automatic longint wrap_aw(input longint v);
        longint m;
        longint r;
        m = longint'(1) << AW;
        r = v & (m - 1);
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    task automatic ref_hop(input int nsf, input int occi, output longint ore, output longint oim);
        longint sr, si, c, s, pr, pi;
        int ph;
        real ang;
        sr = 0;
        si = 0;
        for (int m = 0; m < nsf; m++) begin
            ph = ref_phi(nsf, occi, m);
            if (ph == 0) begin
                sr += bre[m];
                si += bim[m];
            end else begin
                ang = 2.0 * PI * ph / nsf;
                c   = rnd($cos(ang) * 32767.0);
                s   = rnd($sin(ang) * 32767.0);
                pr  = bre[m] * c + bim[m] * s;
                pi  = bim[m] * c - bre[m] * s;
                sr += (pr + 16384) >>> 15;
                si += (pi + 16384) >>> 15;
            end
        end
        ore = wrap_aw(sr);
        oim = wrap_aw(si);
    endtask

    // Start pulse with a junk beat in the same cycle, which must be dropped
    task automatic start_hop(input int nsf, input int occi);
        ifc.i_start = 1'b1;
        ifc.i_nsf   = 3'(nsf);
        ifc.i_occi  = 3'(occi);
        ifc.i_valid = 1'b1;
        ifc.i_re    = DW'($urandom);
        ifc.i_im    = DW'($urandom);
        step();
        ifc.i_start = 1'b0;
        ifc.i_valid = 1'b0;
    endtask

    task automatic send_beats(input int first, input int last, input int maxgap, input string tag);
        int gap;
        for (int m = first; m <= last; m++) begin
            gap = $urandom_range(maxgap, 0);
            repeat (gap) step();
            ifc.i_valid = 1'b1;
            ifc.i_re    = DW'(bre[m]);
            ifc.i_im    = DW'(bim[m]);
            chk({tag, "_rdy"}, longint'(ifc.o_ready), 1);
            step();
            ifc.i_valid = 1'b0;
        end
    endtask

    task automatic run_hop(input int nsf, input int occi, input int maxgap, input string tag,
                           output longint gre, output longint gim);
        int     v0;
        int     k;
        longint ere, eim;
        v0 = n_ovld;
        start_hop(nsf, occi);
        send_beats(0, nsf - 1, maxgap, tag);
        chk({tag, "_rdy_drop"}, longint'(ifc.o_ready), 0);
        k = 0;
        while (k < 10 && ifc.o_valid !== 1'b1) begin
            step();
            k++;
        end
        chk({tag, "_lat"}, k, 2);
        gre = ifc.o_re;
        gim = ifc.o_im;
        ref_hop(nsf, occi, ere, eim);
        chk({tag, "_re"}, gre, ere);
        chk({tag, "_im"}, gim, eim);
        step();
        chk({tag, "_pulse"}, longint'(ifc.o_valid), 0);
        chk({tag, "_hold"}, longint'(ifc.o_re), ere);
        chk({tag, "_nvalid"}, n_ovld - v0, 1);
    endtask

    function automatic longint iabs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    longint gre, gim;
    int     v0, nsf, occi;

    initial begin
        ifc.i_start = 1'b0;
        ifc.i_nsf   = 3'd0;
        ifc.i_occi  = 3'd0;
        ifc.i_valid = 1'b0;
        ifc.i_re    = '0;
        ifc.i_im    = '0;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_ready", longint'(ifc.o_ready), 0);
        chk("rst_busy",  longint'(ifc.o_busy),  0);
        chk("rst_err",   longint'(ifc.o_err),   0);
        chk("rst_valid", longint'(ifc.o_valid), 0);
        chk("rst_re",    longint'(ifc.o_re),    0);
        chk("rst_im",    longint'(ifc.o_im),    0);
        rst = 1'b0;
        step();

        // nSF=2, occi=1: equal beats cancel exactly
        bre[0] = 100; bim[0] = 0; bre[1] = 100; bim[1] = 0;
        run_hop(2, 1, 0, "t1", gre, gim);
        chk("t1_zero_re", gre, 0);
        chk("t1_zero_im", gim, 0);

        // nSF=4, occi=3: cover {+,-,-,+} matches the beats
        bre[0] = 1000;  bre[1] = -1000; bre[2] = -1000; bre[3] = 1000;
        bim[0] = 0;     bim[1] = 0;     bim[2] = 0;     bim[3] = 0;
        run_hop(4, 3, 0, "t2", gre, gim);
        chk("t2_re_tol", longint'(iabs(gre - 4000) <= 4), 1);
        chk("t2_im_tol", longint'(iabs(gim) <= 4), 1);

        // nSF=3 rotating beats: coherent for occi=1, cancelling for occi=2
        bre[0] = 1000; bim[0] = 0;
        bre[1] = -500; bim[1] = 866;
        bre[2] = -500; bim[2] = -866;
        run_hop(3, 1, 1, "t3a", gre, gim);
        chk("t3a_re_tol", longint'(iabs(gre - 3000) <= 3), 1);
        chk("t3a_im_tol", longint'(iabs(gim) <= 3), 1);
        run_hop(3, 2, 1, "t3b", gre, gim);
        chk("t3b_mag", longint'(gre * gre + gim * gim <= 9), 1);

        // nSF=7, occi=5: gap-free and gapped runs against the same reference
        for (int m = 0; m < 7; m++) begin
            bre[m] = rand_s16();
            bim[m] = rand_s16();
        end
        run_hop(7, 5, 0, "t4a", gre, gim);
        run_hop(7, 5, 3, "t4b", gre, gim);

        // Invalid configurations: error pulse, no hop
        ifc.i_start = 1'b1; ifc.i_nsf = 3'd4; ifc.i_occi = 3'd5;
        step();
        ifc.i_start = 1'b0;
        chk("t5a_err",   longint'(ifc.o_err),   1);
        chk("t5a_ready", longint'(ifc.o_ready), 0);
        chk("t5a_busy",  longint'(ifc.o_busy),  0);
        step();
        chk("t5a_err_pulse", longint'(ifc.o_err), 0);
        chk("t5a_ready2",    longint'(ifc.o_ready), 0);
        ifc.i_start = 1'b1; ifc.i_nsf = 3'd1; ifc.i_occi = 3'd0;
        step();
        ifc.i_start = 1'b0;
        chk("t5b_err",   longint'(ifc.o_err),   1);
        chk("t5b_ready", longint'(ifc.o_ready), 0);
        step();
        chk("t5b_err_pulse", longint'(ifc.o_err), 0);

        // Abort in ACC after beat 2, then abort in DRAIN; one result only
        v0 = n_ovld;
        for (int m = 0; m < 5; m++) begin
            bre[m] = rand_s16();
            bim[m] = rand_s16();
        end
        start_hop(5, 2);
        send_beats(0, 2, 1, "t6a");
        start_hop(5, 1);
        send_beats(0, 4, 0, "t6b");
        for (int m = 0; m < 5; m++) begin
            bre[m] = rand_s16();
            bim[m] = rand_s16();
        end
        run_hop(5, 3, 1, "t6c", gre, gim);
        chk("t6_nvalid", n_ovld - v0, 1);

        // Reset in the middle of ACC
        for (int m = 0; m < 6; m++) begin
            bre[m] = rand_s16();
            bim[m] = rand_s16();
        end
        start_hop(6, 1);
        send_beats(0, 1, 0, "t7");
        rst = 1'b1;
        step();
        chk("t7_ready", longint'(ifc.o_ready), 0);
        chk("t7_busy",  longint'(ifc.o_busy),  0);
        chk("t7_valid", longint'(ifc.o_valid), 0);
        chk("t7_err",   longint'(ifc.o_err),   0);
        chk("t7_re",    longint'(ifc.o_re),    0);
        chk("t7_im",    longint'(ifc.o_im),    0);
        rst = 1'b0;
        step();
        run_hop(6, 1, 0, "t7b", gre, gim);

        // Random hops over all valid configurations
        for (int h = 0; h < 30; h++) begin
            nsf  = $urandom_range(7, 2);
            occi = $urandom_range(nsf - 1, 0);
            for (int m = 0; m < 8; m++) begin
                bre[m] = rand_s16();
                bim[m] = rand_s16();
            end
            run_hop(nsf, occi, 2, $sformatf("rnd%0d", h), gre, gim);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
